// File: rtl/aes_spi_frontend.sv
// Serial slave front-end for one AES core: deserialises msg+key, starts the core, serialises the result.
// Optional frame parity bit is enabled by defining AES_SPI_PARITY_EN.
module aes_spi_frontend #(
  parameter int nk = 4,
  parameter int nb = 4,
  parameter int nr = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              Mosi,
  input  logic              in_valid,
  output logic              Miso,
  output logic              out_valid,
  output logic [32*nb-1:0]  core_msg,
  output logic [32*nk-1:0]  core_key,
  output logic              core_start,
  input  logic              core_done,
  input  logic [32*nb-1:0]  core_result,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  localparam int MW = 32 * nb;
  localparam int KW = 32 * nk;
  localparam int DW = MW + KW;
`ifdef AES_SPI_PARITY_EN
  localparam int FLEN = DW + 1;
  localparam int RXW  = DW;
`else
  localparam int FLEN = DW;
  localparam int RXW  = DW - 1;
`endif
  localparam int CW = $clog2(FLEN + 1);

  if (nb != 4 || !(nk == 4 || nk == 6 || nk == 8) || nr != nk + 6) begin : g_bad_cfg
    $error("aes_spi_frontend: unsupported nk/nb/nr combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT, S_SEND} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RXW-1:0]  rx_q, rx_d;
  logic [MW-1:0]   msg_q, msg_d;
  logic [KW-1:0]   key_q, key_d;
  logic            start_q, start_d;
  logic [MW-1:0]   tx_q, tx_d;
  logic            last_q, last_d;
`ifdef AES_SPI_PARITY_EN
  logic            err_q, err_d;
`endif

  // The final frame bit is never shifted into rx: it is either the parity bit or
  // is concatenated directly onto rx when the frame is captured.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    msg_d     = msg_q;
    key_d     = key_q;
    start_d   = 1'b0;
    tx_d      = tx_q;
    last_d    = last_q;
`ifdef AES_SPI_PARITY_EN
    err_d     = err_q;
`endif
    out_valid = 1'b0;
    Miso      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs && in_valid) begin
          rx_d    = {rx_q[RXW-2:0], Mosi};
          cnt_d   = CW'(1);
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (!cs) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (in_valid) begin
          if (cnt_q == CW'(FLEN - 1)) begin
            cnt_d = '0;
`ifdef AES_SPI_PARITY_EN
            if ((^rx_q) == Mosi) begin
              {msg_d, key_d} = rx_q;
              start_d        = 1'b1;
              state_d        = S_WAIT;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
`else
            {msg_d, key_d} = {rx_q, Mosi};
            start_d        = 1'b1;
            state_d        = S_WAIT;
`endif
          end else begin
            rx_d  = {rx_q[RXW-2:0], Mosi};
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (core_done) begin
          tx_d    = core_result;
          last_d  = 1'b0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (cs) begin
          out_valid = 1'b1;
          Miso      = tx_q[MW-1];
          last_d    = tx_q[MW-1];
          tx_d      = {tx_q[MW-2:0], 1'b0};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(MW - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          Miso = last_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      msg_q   <= '0;
      key_q   <= '0;
      start_q <= 1'b0;
      tx_q    <= '0;
      last_q  <= 1'b0;
`ifdef AES_SPI_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      msg_q   <= msg_d;
      key_q   <= key_d;
      start_q <= start_d;
      tx_q    <= tx_d;
      last_q  <= last_d;
`ifdef AES_SPI_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign core_msg   = msg_q;
  assign core_key   = key_q;
  assign core_start = start_q;
  assign dbg_state  = state_q;
`ifdef AES_SPI_PARITY_EN
  assign frame_err  = err_q;
`else
  assign frame_err  = 1'b0;
`endif

endmodule
